// File: rtl/dpd_lut_cfg_master.sv
// DPD LUT configuration master.
// Turns write/read burst commands into single-word accesses on a LUT config
// port (enc/wec/addrc/dinc/doutc). Read data returns through a small FIFO
// whose occupancy, including reads still in flight, throttles read issue.
module dpd_lut_cfg_master #(
    parameter int I_DELAY_MAX = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int RD_LATENCY  = 3,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic                           cmd_write,
    input  logic [$clog2(I_DELAY_MAX)-1:0] cmd_lut,
    input  logic [ADDR_WIDTH-1:0]          cmd_addr,
    input  logic [ADDR_WIDTH:0]            cmd_len,
    input  logic                           wr_valid,
    output logic                           wr_ready,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    output logic                           rd_valid,
    input  logic                           rd_ready,
    output logic [DATA_WIDTH-1:0]          rd_data,
    output logic                           enc,
    output logic                           wec,
    output logic [I_DELAY_MAX-1:0]         lutIdc,
    output logic [ADDR_WIDTH-1:0]          addrc,
    output logic [DATA_WIDTH-1:0]          dinc,
    input  logic [DATA_WIDTH-1:0]          doutc,
    output logic                           busy,
    output logic                           done,
    output logic                           err
);
    localparam int LUT_W = $clog2(I_DELAY_MAX);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W = $clog2(FIFO_DEPTH + RD_LATENCY + 2);

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH:0]     cnt_q, cnt_d;
    logic                    enc_q, enc_d, wec_q, wec_d;
    logic                    busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [I_DELAY_MAX-1:0]  lut_q, lut_d;
    logic [ADDR_WIDTH-1:0]   addrc_q, addrc_d;
    logic [DATA_WIDTH-1:0]   dinc_q, dinc_d;
    logic [RD_LATENCY-1:0]   rd_sr_q, rd_sr_d;
    logic [DATA_WIDTH-1:0]   fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [I_DELAY_MAX-1:0]  cmd_oh;
    logic [OCC_W-1:0]        inflight;
    logic                    push, pop, issue_ok;

    // One-hot decode of the requested LUT; an out-of-range index decodes to zero.
    for (genvar gi = 0; gi < I_DELAY_MAX; gi++) begin : g_oh
        assign cmd_oh[gi] = (cmd_lut == LUT_W'(gi));
    end

    // Read-valid shift register: stage 0 sees the read visible on the port now.
    assign rd_sr_d[0] = enc_q & ~wec_q;
    for (genvar gi = 1; gi < RD_LATENCY; gi++) begin : g_sr
        assign rd_sr_d[gi] = rd_sr_q[gi-1];
    end

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Words already promised to the FIFO: stored, in the pipe, or on the port.
    always_comb begin
        inflight = OCC_W'(count_q) + OCC_W'(rd_sr_d[0]);
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + OCC_W'(rd_sr_q[i]);
        end
    end

    assign issue_ok = (inflight < OCC_W'(FIFO_DEPTH));
    assign push     = rd_sr_q[RD_LATENCY-1];
    assign pop      = (count_q != '0) & rd_ready;

    // Read-return FIFO pointer and occupancy update; push and pop may coincide.
    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // Next-state and next-output logic for the burst sequencer.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        lut_d   = lut_q;
        enc_d   = 1'b0;
        wec_d   = 1'b0;
        addrc_d = addrc_q;
        dinc_d  = dinc_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d = cmd_addr;
                    cnt_d  = cmd_len;
                    if (cmd_len == '0 || cmd_oh == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d = cmd_write ? WRITE : READ;
                        lut_d   = cmd_oh;
                        busy_d  = 1'b1;
                    end
                end
            end
            WRITE: begin
                // Stay one cycle after the last issue so its enc is seen in WRITE.
                if (cnt_q == '0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    lut_d   = '0;
                end else if (wr_valid) begin
                    enc_d   = 1'b1;
                    wec_d   = 1'b1;
                    addrc_d = addr_q;
                    dinc_d  = wr_data;
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                    cnt_d   = cnt_q - (ADDR_WIDTH+1)'(1);
                end
            end
            READ: begin
                if (cnt_q == '0) begin
                    state_d = DRAIN;
                end else if (issue_ok) begin
                    enc_d   = 1'b1;
                    addrc_d = addr_q;
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                    cnt_d   = cnt_q - (ADDR_WIDTH+1)'(1);
                end
            end
            DRAIN: begin
                if (rd_sr_q == '0 && count_q == '0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    lut_d   = '0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer state and registered config-port / status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            lut_q   <= '0;
            enc_q   <= 1'b0;
            wec_q   <= 1'b0;
            addrc_q <= '0;
            dinc_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rd_sr_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            lut_q   <= lut_d;
            enc_q   <= enc_d;
            wec_q   <= wec_d;
            addrc_q <= addrc_d;
            dinc_q  <= dinc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rd_sr_q <= rd_sr_d;
        end
    end

    // Read-return FIFO storage; cleared on reset so rd_data reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_mem_q[wr_ptr_q] <= doutc;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign wr_ready  = (state_q == WRITE) && (cnt_q != '0);
    assign rd_valid  = (count_q != '0);
    assign rd_data   = fifo_mem_q[rd_ptr_q];
    assign enc       = enc_q;
    assign wec       = wec_q;
    assign lutIdc    = lut_q;
    assign addrc     = addrc_q;
    assign dinc      = dinc_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_dpd_lut_cfg_master.sv
// Bench for dpd_lut_cfg_master: table of burst commands with hand-computed
// results, plus directed sequences for read back-pressure, an out-of-range
// LUT index (second instance with 6 LUTs) and reset in the middle of a write.
module tb_dpd_lut_cfg_master;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_valid2 = 1'b0;
    logic        cmd_ready, cmd_ready2;
    logic        cmd_write = 1'b0;
    logic [2:0]  cmd_lut = '0;
    logic [9:0]  cmd_addr = '0;
    logic [10:0] cmd_len = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready, wr_ready2;
    logic [31:0] wr_data;
    logic        rd_valid, rd_valid2;
    logic        rd_ready = 1'b0;
    logic [31:0] rd_data, rd_data2;
    logic        enc, wec, enc2, wec2;
    logic [7:0]  lutIdc;
    logic [5:0]  lutIdc2;
    logic [9:0]  addrc, addrc2;
    logic [31:0] dinc, dinc2;
    logic [31:0] doutc;
    logic        busy, done, err, busy2, done2, err2;

    always #5 clk = ~clk;

    dpd_lut_cfg_master dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_lut(cmd_lut), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .enc(enc), .wec(wec), .lutIdc(lutIdc), .addrc(addrc), .dinc(dinc), .doutc(doutc),
        .busy(busy), .done(done), .err(err)
    );

    dpd_lut_cfg_master #(.I_DELAY_MAX(6)) dut2 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
        .cmd_write(cmd_write), .cmd_lut(cmd_lut), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready2), .wr_data(wr_data),
        .rd_valid(rd_valid2), .rd_ready(rd_ready), .rd_data(rd_data2),
        .enc(enc2), .wec(wec2), .lutIdc(lutIdc2), .addrc(addrc2), .dinc(dinc2), .doutc(doutc),
        .busy(busy2), .done(done2), .err(err2)
    );

    // LUT RAM model: read data = addr + 0xA500, valid 3 cycles after enc.
    logic       pv [3] = '{1'b0, 1'b0, 1'b0};
    logic [9:0] pa [3] = '{10'h0, 10'h0, 10'h0};
    always @(posedge clk) begin
        pv[0] <= enc & ~wec;
        pa[0] <= addrc;
        pv[1] <= pv[0];
        pa[1] <= pa[0];
        pv[2] <= pv[1];
        pa[2] <= pa[1];
    end
    assign doutc = pv[2] ? (32'hA500 + {22'h0, pa[2]}) : 32'hDEAD_BEEF;

    // Write-data source: next word index advances on each handshake.
    logic [31:0] hs_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) hs_cnt <= '0;
        else if (wr_valid && wr_ready) hs_cnt <= hs_cnt + 32'd1;
    end
    assign wr_data = 32'hC0DE_0000 + hs_cnt;

    // Monitor state and expectations.
    int         n_enc, n_addr_err, n_wec_err, n_din_err, n_enc_idle, n_oh_err;
    int         n_rd, n_rd_err, n_done, n_err, n_err_nodone;
    int         n_enc2, n_done2, n_err2;
    int         wr_seq = 0;
    logic [9:0] exp_addr, exp_rd_addr, last_addr;
    logic [7:0] exp_oh;
    logic       exp_wec;
    int         n_checks = 0, n_fail = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (enc) begin
                n_enc++;
                last_addr = addrc;
                if (addrc !== exp_addr) n_addr_err++;
                exp_addr = exp_addr + 10'd1;
                if (wec !== exp_wec) n_wec_err++;
                if (wec) begin
                    if (dinc !== 32'hC0DE_0000 + wr_seq) n_din_err++;
                    wr_seq++;
                end
                if (!busy) n_enc_idle++;
            end
            if (busy ? (lutIdc !== exp_oh) : (lutIdc !== 8'h00)) n_oh_err++;
            if (rd_valid && rd_ready) begin
                n_rd++;
                if (rd_data !== 32'hA500 + {22'h0, exp_rd_addr}) n_rd_err++;
                exp_rd_addr = exp_rd_addr + 10'd1;
            end
            if (done) n_done++;
            if (err) n_err++;
            if (err && !done) n_err_nodone++;
            if (enc2) n_enc2++;
            if (done2) n_done2++;
            if (err2) n_err2++;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic clear_counters(input logic [9:0] a, input logic [7:0] oh, input logic w);
        n_enc = 0; n_addr_err = 0; n_wec_err = 0; n_din_err = 0; n_enc_idle = 0;
        n_oh_err = 0; n_rd = 0; n_rd_err = 0; n_done = 0; n_err = 0; n_err_nodone = 0;
        n_enc2 = 0; n_done2 = 0; n_err2 = 0;
        exp_addr = a; exp_rd_addr = a; exp_oh = oh; exp_wec = w; last_addr = '0;
    endtask

    // Wait (sampling 1 time unit after each edge) for done, bounded.
    task automatic wait_done(input int budget, input string name);
        int t;
        t = 0;
        while (!done && t < budget) begin
            @(posedge clk); #1;
            t++;
        end
        check(name, 64'(t < budget), 64'd1);
    endtask

    typedef struct {
        logic        w;
        logic [2:0]  lut;
        logic [9:0]  addr;
        logic [10:0] len;
        logic [7:0]  exp_oh;
        int          exp_enc;
        int          exp_rd;
        logic        exp_err;
        logic [9:0]  exp_last;
    } vec_t;

    vec_t tbl [8];

    task automatic run_row(input int idx, input vec_t v);
        int   t;
        logic busy_acc;
        @(posedge clk); #1;
        clear_counters(v.addr, v.exp_oh, v.w);
        cmd_write = v.w; cmd_lut = v.lut; cmd_addr = v.addr; cmd_len = v.len;
        cmd_valid = 1'b1; wr_valid = v.w; rd_ready = 1'b1;
        t = 0;
        while (!cmd_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("cmd_ready_wait", 64'(t < 50), 64'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        busy_acc = busy;
        wait_done(3000, "done_timeout");
        repeat (3) @(posedge clk);
        #1;
        wr_valid = 1'b0;
        check("busy_after_accept", 64'(busy_acc), 64'(!v.exp_err));
        check("done_count", 64'(n_done), 64'd1);
        check("err_count", 64'(n_err), 64'(v.exp_err));
        check("err_without_done", 64'(n_err_nodone), 64'd0);
        check("enc_count", 64'(n_enc), 64'(v.exp_enc));
        check("addr_sequence", 64'(n_addr_err), 64'd0);
        check("wec_level", 64'(n_wec_err), 64'd0);
        check("dinc_data", 64'(n_din_err), 64'd0);
        check("lutIdc", 64'(n_oh_err), 64'd0);
        check("enc_outside_busy", 64'(n_enc_idle), 64'd0);
        check("rd_count", 64'(n_rd), 64'(v.exp_rd));
        check("rd_data", 64'(n_rd_err), 64'd0);
        if (v.exp_enc > 0) check("last_addrc", 64'(last_addr), 64'(v.exp_last));
        $display("row %0d: w=%0d lut=%0d addr=%h len=%0d -> enc=%0d rd=%0d done=%0d err=%0d",
                 idx, v.w, v.lut, v.addr, v.len, n_enc, n_rd, n_done, n_err);
    endtask

    initial begin
        int t;
        //          w     lut   addr     len      oh     enc   rd  err   last
        tbl[0] = '{1'b1, 3'd2, 10'h3FE, 11'd4,    8'h04, 4,    0,  1'b0, 10'h001};
        tbl[1] = '{1'b0, 3'd5, 10'h010, 11'd8,    8'h20, 8,    8,  1'b0, 10'h017};
        tbl[2] = '{1'b1, 3'd0, 10'h100, 11'd1,    8'h01, 1,    0,  1'b0, 10'h100};
        tbl[3] = '{1'b0, 3'd7, 10'h3FF, 11'd2,    8'h80, 2,    2,  1'b0, 10'h000};
        tbl[4] = '{1'b1, 3'd3, 10'h055, 11'd0,    8'h00, 0,    0,  1'b1, 10'h000};
        tbl[5] = '{1'b0, 3'd6, 10'h000, 11'd0,    8'h00, 0,    0,  1'b1, 10'h000};
        tbl[6] = '{1'b1, 3'd1, 10'h000, 11'h400,  8'h02, 1024, 0,  1'b0, 10'h3FF};
        tbl[7] = '{1'b0, 3'd4, 10'h200, 11'd5,    8'h10, 5,    5,  1'b0, 10'h204};

        // Reset values while rst_n is low, then ready after release.
        repeat (3) @(posedge clk);
        #1;
        check("reset_cfg_port", 64'({enc, wec, lutIdc, addrc}), 64'd0);
        check("reset_dinc", 64'(dinc), 64'd0);
        check("reset_status", 64'({rd_valid, busy, done, err}), 64'd0);
        check("reset_rd_data", 64'(rd_data), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("cmd_ready_after_reset", 64'(cmd_ready), 64'd1);
        $display("reset: cmd_ready=%0d busy=%0d rd_valid=%0d", cmd_ready, busy, rd_valid);

        // Out-of-range LUT index on a 6-LUT instance.
        clear_counters(10'h0, 8'h00, 1'b0);
        cmd_write = 1'b0; cmd_lut = 3'd6; cmd_addr = 10'h0; cmd_len = 11'd3;
        cmd_valid2 = 1'b1;
        @(posedge clk); #1;
        cmd_valid2 = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("lut_range_err", 64'(n_err2), 64'd1);
        check("lut_range_done", 64'(n_done2), 64'd1);
        check("lut_range_enc", 64'(n_enc2), 64'd0);
        $display("lut range: lut=6 of 6 -> err=%0d done=%0d enc=%0d", n_err2, n_done2, n_enc2);

        for (int i = 0; i < 8; i++) run_row(i, tbl[i]);

        // Read with rd_ready held low: four issues fill the FIFO, then stall.
        @(posedge clk); #1;
        clear_counters(10'h010, 8'h20, 1'b0);
        cmd_write = 1'b0; cmd_lut = 3'd5; cmd_addr = 10'h010; cmd_len = 11'd8;
        rd_ready = 1'b0; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("stall_issue_count", 64'(n_enc), 64'd4);
        check("stall_rd_valid", 64'(rd_valid), 64'd1);
        check("stall_lutIdc", 64'(lutIdc), 64'h20);
        rd_ready = 1'b1;
        wait_done(200, "stall_done_timeout");
        repeat (3) @(posedge clk);
        #1;
        check("stall_enc_total", 64'(n_enc), 64'd8);
        check("stall_rd_count", 64'(n_rd), 64'd8);
        check("stall_rd_data", 64'(n_rd_err), 64'd0);
        check("stall_addr_sequence", 64'(n_addr_err), 64'd0);
        check("stall_done", 64'(n_done), 64'd1);
        $display("stall: enc=%0d rd=%0d rd_err=%0d done=%0d", n_enc, n_rd, n_rd_err, n_done);

        // Reset asserted during the second word of a 6-word write.
        clear_counters(10'h000, 8'h08, 1'b1);
        cmd_write = 1'b1; cmd_lut = 3'd3; cmd_addr = 10'h000; cmd_len = 11'd6;
        wr_valid = 1'b1; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        t = 0;
        while (n_enc < 2 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("midreset_wait", 64'(t < 50), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset_cfg_port", 64'({enc, wec, lutIdc, addrc}), 64'd0);
        check("midreset_dinc", 64'(dinc), 64'd0);
        check("midreset_status", 64'({rd_valid, busy, done, err}), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wr_seq = 0;
        @(posedge clk); #1;
        check("midreset_cmd_ready", 64'(cmd_ready), 64'd1);
        check("midreset_wr_ready", 64'(wr_ready), 64'd0);
        repeat (20) @(posedge clk);
        #1;
        check("midreset_no_done", 64'(n_done), 64'd0);
        check("midreset_no_consume", 64'(hs_cnt), 64'd0);
        check("midreset_no_enc", 64'(n_enc), 64'd2);
        wr_valid = 1'b0;
        $display("midreset: enc_before=%0d done=%0d consumed_after=%0d", n_enc, n_done, hs_cnt);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
